pc_fetch_sequencer: RTL

Sequencer that owns the miniMIPS program counter register and runs the fetch/execute/update loop around the next-PC arithmetic (pc+1, or pc+1+branch offset). It issues instruction-memory requests, holds the fetched instruction for the datapath, waits for execute completion, and commits the next PC. It sits between the instruction memory, the decode/execute datapath and the top-level run control.

---
 rtl/miniMIPS_pkg.sv | 17 +
 rtl/pc_next_logic.sv | 23 ++
 rtl/pc_fetch_sequencer.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/miniMIPS_pkg.sv
// Shared miniMIPS definitions: sequencer state encoding and default geometry.
package miniMIPS_pkg;

    localparam int unsigned PC_WIDTH_DEF  = 6;
    localparam int unsigned RESET_PC_DEF  = 0;
    localparam int unsigned CNT_WIDTH_DEF = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_EXEC,
        ST_UPDATE,
        ST_HALT,
        ST_FAULT
    } seq_state_e;

endpackage

// File: rtl/pc_next_logic.sv
// Next-PC arithmetic: pc+1 or pc+1+offset in 32 bits, plus out-of-range detection.
module pc_next_logic #(
    parameter int unsigned PC_WIDTH = 6
) (
    input  logic [PC_WIDTH-1:0] pc_i,
    input  logic                branch_i,
    input  logic [31:0]         branch_offset_i,
    output logic [PC_WIDTH-1:0] next_pc_o,
    output logic                range_error_o
);

    localparam logic [31:0] PC_MAX = 32'((64'd1 << PC_WIDTH) - 64'd1);

    logic [31:0] target;

    always_comb begin
        target        = 32'(pc_i) + 32'd1 + (branch_i ? branch_offset_i : '0);
        next_pc_o     = target[PC_WIDTH-1:0];
        // Negative targets show up as bit 31 set; positive overshoot as > PC_MAX.
        range_error_o = target[31] || (target > PC_MAX);
    end

endmodule

// File: rtl/pc_fetch_sequencer.sv
// miniMIPS fetch/execute/update sequencer owning the PC and retired counter.
// Optional PC_RANGE_CHECK_EN: out-of-range next PC traps into a sticky FAULT state.
module pc_fetch_sequencer
    import miniMIPS_pkg::*;
#(
    parameter int unsigned PC_WIDTH  = PC_WIDTH_DEF,
    parameter int unsigned RESET_PC  = RESET_PC_DEF,
    parameter int unsigned CNT_WIDTH = CNT_WIDTH_DEF
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 halt_req,
    output logic                 imem_req,
    output logic [PC_WIDTH-1:0]  imem_addr,
    input  logic                 imem_ack,
    input  logic [31:0]          imem_data,
    output logic [31:0]          instr,
    output logic                 instr_valid,
    input  logic                 instr_done,
    input  logic                 branch,
    input  logic [31:0]          branch_offset,
    output logic [PC_WIDTH-1:0]  pc,
    output logic                 running,
    output logic                 halted,
    output logic                 fault,
    output logic [CNT_WIDTH-1:0] retired
);

    seq_state_e           state_q, state_d;
    logic [PC_WIDTH-1:0]  pc_q, pc_d;
    logic [31:0]          instr_q, instr_d;
    logic [CNT_WIDTH-1:0] retired_q, retired_d;
    logic                 halt_pending_q, halt_pending_d;
    logic                 branch_q, branch_d;
    logic [31:0]          offset_q, offset_d;

    logic [PC_WIDTH-1:0]  next_pc;
    logic                 range_err;
    logic                 trap;

    pc_next_logic #(
        .PC_WIDTH (PC_WIDTH)
    ) u_pc_next (
        .pc_i            (pc_q),
        .branch_i        (branch_q),
        .branch_offset_i (offset_q),
        .next_pc_o       (next_pc),
        .range_error_o   (range_err)
    );

`ifdef PC_RANGE_CHECK_EN
    assign trap  = range_err;
    assign fault = (state_q == ST_FAULT);
`else
    logic unused_range_err;
    assign unused_range_err = range_err;
    assign trap  = 1'b0;
    assign fault = 1'b0;
`endif

    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        instr_d        = instr_q;
        retired_d      = retired_q;
        branch_d       = branch_q;
        offset_d       = offset_q;
        halt_pending_d = halt_pending_q;

        if (state_q != ST_IDLE && halt_req)
            halt_pending_d = 1'b1;

        case (state_q)
            ST_IDLE: begin
                if (start)
                    state_d = ST_FETCH;
            end
            ST_FETCH: begin
                // A same-cycle ack takes priority over a pending halt.
                if (imem_ack) begin
                    instr_d = imem_data;
                    state_d = ST_EXEC;
                end else if (halt_pending_q) begin
                    state_d = ST_HALT;
                end
            end
            ST_EXEC: begin
                if (instr_done) begin
                    branch_d = branch;
                    offset_d = branch_offset;
                    state_d  = ST_UPDATE;
                end
            end
            ST_UPDATE: begin
                if (trap) begin
                    state_d = ST_FAULT;
                end else begin
                    pc_d      = next_pc;
                    retired_d = retired_q + 1'b1;
                    state_d   = halt_pending_q ? ST_HALT : ST_FETCH;
                end
            end
            ST_HALT: begin
                if (start) begin
                    halt_pending_d = 1'b0;
                    state_d        = ST_FETCH;
                end
            end
            ST_FAULT: state_d = ST_FAULT;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            pc_q           <= PC_WIDTH'(RESET_PC);
            instr_q        <= '0;
            retired_q      <= '0;
            halt_pending_q <= 1'b0;
            branch_q       <= 1'b0;
            offset_q       <= '0;
        end else begin
            state_q        <= state_d;
            pc_q           <= pc_d;
            instr_q        <= instr_d;
            retired_q      <= retired_d;
            halt_pending_q <= halt_pending_d;
            branch_q       <= branch_d;
            offset_q       <= offset_d;
        end
    end

    assign imem_req    = (state_q == ST_FETCH);
    assign imem_addr   = pc_q;
    assign instr       = instr_q;
    assign instr_valid = (state_q == ST_EXEC);
    assign pc          = pc_q;
    assign running     = (state_q == ST_FETCH) || (state_q == ST_EXEC) || (state_q == ST_UPDATE);
    assign halted      = (state_q == ST_HALT);
    assign retired     = retired_q;

endmodule
